// File: rtl/alu_decode_pipe_pkg.sv
// Shared ALU-control constants: MIPS opcode/funct/rt encodings and the EXE_*_OP codes.
// The reserved-instruction flag is a single bit per lane alongside its EXE_*_OP code.
package alu_decode_pipe_pkg;

    localparam int unsigned ALUOP_W = 8;
    typedef logic [ALUOP_W-1:0] aluop_t;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_REGIMM  = 6'b000001;
    localparam logic [5:0] EXE_J       = 6'b000010;
    localparam logic [5:0] EXE_JAL     = 6'b000011;
    localparam logic [5:0] EXE_BEQ     = 6'b000100;
    localparam logic [5:0] EXE_BNE     = 6'b000101;
    localparam logic [5:0] EXE_BLEZ    = 6'b000110;
    localparam logic [5:0] EXE_BGTZ    = 6'b000111;
    localparam logic [5:0] EXE_ADDI    = 6'b001000;
    localparam logic [5:0] EXE_ADDIU   = 6'b001001;
    localparam logic [5:0] EXE_SLTI    = 6'b001010;
    localparam logic [5:0] EXE_SLTIU   = 6'b001011;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;

    // SPECIAL funct field
    localparam logic [5:0] EXE_SLL   = 6'b000000;
    localparam logic [5:0] EXE_SRL   = 6'b000010;
    localparam logic [5:0] EXE_SRA   = 6'b000011;
    localparam logic [5:0] EXE_SLLV  = 6'b000100;
    localparam logic [5:0] EXE_SRLV  = 6'b000110;
    localparam logic [5:0] EXE_SRAV  = 6'b000111;
    localparam logic [5:0] EXE_JR    = 6'b001000;
    localparam logic [5:0] EXE_JALR  = 6'b001001;
    localparam logic [5:0] EXE_MFHI  = 6'b010000;
    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MFLO  = 6'b010010;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_ADD   = 6'b100000;
    localparam logic [5:0] EXE_ADDU  = 6'b100001;
    localparam logic [5:0] EXE_SUB   = 6'b100010;
    localparam logic [5:0] EXE_SUBU  = 6'b100011;
    localparam logic [5:0] EXE_AND   = 6'b100100;
    localparam logic [5:0] EXE_OR    = 6'b100101;
    localparam logic [5:0] EXE_XOR   = 6'b100110;
    localparam logic [5:0] EXE_NOR   = 6'b100111;
    localparam logic [5:0] EXE_SLT   = 6'b101010;
    localparam logic [5:0] EXE_SLTU  = 6'b101011;

    // REGIMM rt field
    localparam logic [4:0] EXE_BLTZ   = 5'b00000;
    localparam logic [4:0] EXE_BGEZ   = 5'b00001;
    localparam logic [4:0] EXE_BLTZAL = 5'b10000;
    localparam logic [4:0] EXE_BGEZAL = 5'b10001;

    // ALU control codes
    localparam aluop_t EXE_NOP_OP    = 8'h00;
    localparam aluop_t EXE_AND_OP    = 8'h01;
    localparam aluop_t EXE_OR_OP     = 8'h02;
    localparam aluop_t EXE_XOR_OP    = 8'h03;
    localparam aluop_t EXE_NOR_OP    = 8'h04;
    localparam aluop_t EXE_SLL_OP    = 8'h05;
    localparam aluop_t EXE_SLLV_OP   = 8'h06;
    localparam aluop_t EXE_SRL_OP    = 8'h07;
    localparam aluop_t EXE_SRLV_OP   = 8'h08;
    localparam aluop_t EXE_SRA_OP    = 8'h09;
    localparam aluop_t EXE_SRAV_OP   = 8'h0A;
    localparam aluop_t EXE_MFHI_OP   = 8'h0B;
    localparam aluop_t EXE_MTHI_OP   = 8'h0C;
    localparam aluop_t EXE_MFLO_OP   = 8'h0D;
    localparam aluop_t EXE_MTLO_OP   = 8'h0E;
    localparam aluop_t EXE_ADD_OP    = 8'h0F;
    localparam aluop_t EXE_ADDU_OP   = 8'h10;
    localparam aluop_t EXE_SUB_OP    = 8'h11;
    localparam aluop_t EXE_SUBU_OP   = 8'h12;
    localparam aluop_t EXE_SLT_OP    = 8'h13;
    localparam aluop_t EXE_SLTU_OP   = 8'h14;
    localparam aluop_t EXE_MULT_OP   = 8'h15;
    localparam aluop_t EXE_MULTU_OP  = 8'h16;
    localparam aluop_t EXE_DIV_OP    = 8'h17;
    localparam aluop_t EXE_DIVU_OP   = 8'h18;
    localparam aluop_t EXE_JR_OP     = 8'h19;
    localparam aluop_t EXE_JALR_OP   = 8'h1A;
    localparam aluop_t EXE_BLTZ_OP   = 8'h1B;
    localparam aluop_t EXE_BGEZ_OP   = 8'h1C;
    localparam aluop_t EXE_BLTZAL_OP = 8'h1D;
    localparam aluop_t EXE_BGEZAL_OP = 8'h1E;
    localparam aluop_t EXE_ANDI_OP   = 8'h1F;
    localparam aluop_t EXE_ORI_OP    = 8'h20;
    localparam aluop_t EXE_XORI_OP   = 8'h21;
    localparam aluop_t EXE_LUI_OP    = 8'h22;
    localparam aluop_t EXE_ADDI_OP   = 8'h23;
    localparam aluop_t EXE_ADDIU_OP  = 8'h24;
    localparam aluop_t EXE_SLTI_OP   = 8'h25;
    localparam aluop_t EXE_SLTIU_OP  = 8'h26;
    localparam aluop_t EXE_J_OP      = 8'h27;
    localparam aluop_t EXE_JAL_OP    = 8'h28;
    localparam aluop_t EXE_BEQ_OP    = 8'h29;
    localparam aluop_t EXE_BNE_OP    = 8'h2A;
    localparam aluop_t EXE_BGTZ_OP   = 8'h2B;
    localparam aluop_t EXE_BLEZ_OP   = 8'h2C;

endpackage

// File: rtl/alu_decode_pipe_lane.sv
// Combinational per-lane decoder: opcode/rt/funct fields -> ALU control code and reserved flag.
module alu_decode_lane
    import alu_decode_pipe_pkg::*;
#(
    parameter int unsigned OP_W = 8
) (
    input  logic [5:0]      op,
    input  logic [4:0]      rt,
    input  logic [5:0]      funct,
    output logic [OP_W-1:0] alucontrol_c,
    output logic            ri_c
);

    aluop_t code;

    always_comb begin
        code = EXE_NOP_OP;
        ri_c = 1'b0;
        case (op)
            EXE_SPECIAL: begin
                case (funct)
                    EXE_AND:   code = EXE_AND_OP;
                    EXE_OR:    code = EXE_OR_OP;
                    EXE_XOR:   code = EXE_XOR_OP;
                    EXE_NOR:   code = EXE_NOR_OP;
                    EXE_SLL:   code = EXE_SLL_OP;
                    EXE_SLLV:  code = EXE_SLLV_OP;
                    EXE_SRL:   code = EXE_SRL_OP;
                    EXE_SRLV:  code = EXE_SRLV_OP;
                    EXE_SRA:   code = EXE_SRA_OP;
                    EXE_SRAV:  code = EXE_SRAV_OP;
                    EXE_MFHI:  code = EXE_MFHI_OP;
                    EXE_MTHI:  code = EXE_MTHI_OP;
                    EXE_MFLO:  code = EXE_MFLO_OP;
                    EXE_MTLO:  code = EXE_MTLO_OP;
                    EXE_ADD:   code = EXE_ADD_OP;
                    EXE_ADDU:  code = EXE_ADDU_OP;
                    EXE_SUB:   code = EXE_SUB_OP;
                    EXE_SUBU:  code = EXE_SUBU_OP;
                    EXE_SLT:   code = EXE_SLT_OP;
                    EXE_SLTU:  code = EXE_SLTU_OP;
                    EXE_MULT:  code = EXE_MULT_OP;
                    EXE_MULTU: code = EXE_MULTU_OP;
                    EXE_DIV:   code = EXE_DIV_OP;
                    EXE_DIVU:  code = EXE_DIVU_OP;
                    EXE_JR:    code = EXE_JR_OP;
                    EXE_JALR:  code = EXE_JALR_OP;
                    default:   ri_c = 1'b1;
                endcase
            end
            EXE_REGIMM: begin
                case (rt)
                    EXE_BLTZ:   code = EXE_BLTZ_OP;
                    EXE_BGEZ:   code = EXE_BGEZ_OP;
                    EXE_BLTZAL: code = EXE_BLTZAL_OP;
                    EXE_BGEZAL: code = EXE_BGEZAL_OP;
                    default:    ri_c = 1'b1;
                endcase
            end
            EXE_ANDI:  code = EXE_ANDI_OP;
            EXE_ORI:   code = EXE_ORI_OP;
            EXE_XORI:  code = EXE_XORI_OP;
            EXE_LUI:   code = EXE_LUI_OP;
            EXE_ADDI:  code = EXE_ADDI_OP;
            EXE_ADDIU: code = EXE_ADDIU_OP;
            EXE_SLTI:  code = EXE_SLTI_OP;
            EXE_SLTIU: code = EXE_SLTIU_OP;
            EXE_J:     code = EXE_J_OP;
            EXE_JAL:   code = EXE_JAL_OP;
            EXE_BEQ:   code = EXE_BEQ_OP;
            EXE_BNE:   code = EXE_BNE_OP;
            EXE_BGTZ:  code = EXE_BGTZ_OP;
            EXE_BLEZ:  code = EXE_BLEZ_OP;
            default:   ri_c = 1'b1;
        endcase
    end

    assign alucontrol_c = OP_W'(code);

endmodule

// File: rtl/alu_decode_pipe.sv
// Multi-lane registered ALU-control decoder with a 2-entry skid buffer on a valid/ready handshake.
// Beats are decoded on entry; out_* come straight from the head register.
module alu_decode_pipe
    import alu_decode_pipe_pkg::*;
#(
    parameter int unsigned LANES   = 1,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned OP_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*INSTR_W-1:0] in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*INSTR_W-1:0] out_instr,
    output logic [LANES*OP_W-1:0]    out_alucontrol,
    output logic [LANES-1:0]         out_ri
);

    localparam int unsigned IW = LANES * INSTR_W;
    localparam int unsigned AW = LANES * OP_W;
    localparam logic [AW-1:0] NOP_ALL = {LANES{OP_W'(EXE_NOP_OP)}};

    logic [AW-1:0]    dec_alu;
    logic [LANES-1:0] dec_ri;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_decode_lane #(.OP_W(OP_W)) u_lane (
            .op           (in_instr[i*INSTR_W+26 +: 6]),
            .rt           (in_instr[i*INSTR_W+16 +: 5]),
            .funct        (in_instr[i*INSTR_W +: 6]),
            .alucontrol_c (dec_alu[i*OP_W +: OP_W]),
            .ri_c         (dec_ri[i])
        );
    end

    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [IW-1:0]    skid_instr;
    logic [AW-1:0]    skid_alu;
    logic [LANES-1:0] skid_ri;
    logic             push;
    logic             pop;
    logic             load_head_new;
    logic             load_head_skid;
    logic             load_skid;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Occupancy and load steering; flush overrides any push/pop this cycle.
    always_comb begin
        count_next     = count;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            case (count)
                2'd0: if (push) begin
                    count_next    = 2'd1;
                    load_head_new = 1'b1;
                end
                2'd1: if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    count_next = 2'd2;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    count_next = 2'd0;
                end
                2'd2: if (pop) begin
                    count_next     = 2'd1;
                    load_head_skid = 1'b1;
                end
                default: count_next = 2'd0;
            endcase
        end
    end

    // Flags are registered copies of count_next so in_ready never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count          <= 2'd0;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
            out_instr      <= '0;
            out_alucontrol <= NOP_ALL;
            out_ri         <= '0;
            skid_instr     <= '0;
            skid_alu       <= NOP_ALL;
            skid_ri        <= '0;
        end else begin
            count     <= count_next;
            out_valid <= (count_next != 2'd0);
            in_ready  <= (count_next != 2'd2);
            if (load_head_new) begin
                out_instr      <= in_instr;
                out_alucontrol <= dec_alu;
                out_ri         <= dec_ri;
            end else if (load_head_skid) begin
                out_instr      <= skid_instr;
                out_alucontrol <= skid_alu;
                out_ri         <= skid_ri;
            end
            if (load_skid) begin
                skid_instr <= in_instr;
                skid_alu   <= dec_alu;
                skid_ri    <= dec_ri;
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe: a 1-lane instance for vectors and handshake corners,
// a 2-lane instance for lane packing and random traffic against a queue model.
module tb_alu_decode_pipe;
    import alu_decode_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_instr1, out_instr1;
    logic [7:0]  out_alu1;
    logic [0:0]  out_ri1;

    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [63:0] in_instr2, out_instr2;
    logic [15:0] out_alu2;
    logic [1:0]  out_ri2;

    alu_decode_pipe #(.LANES(1), .INSTR_W(32), .OP_W(8)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_instr(in_instr1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_instr(out_instr1), .out_alucontrol(out_alu1), .out_ri(out_ri1)
    );

    alu_decode_pipe #(.LANES(2), .INSTR_W(32), .OP_W(8)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_alucontrol(out_alu2), .out_ri(out_ri2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode: lookup tables keyed by the ISA field values.
    aluop_t sp_map[int];
    aluop_t rt_map[int];
    aluop_t op_map[int];

    function automatic void build_maps();
        sp_map[32'h00] = EXE_SLL_OP;   sp_map[32'h02] = EXE_SRL_OP;   sp_map[32'h03] = EXE_SRA_OP;
        sp_map[32'h04] = EXE_SLLV_OP;  sp_map[32'h06] = EXE_SRLV_OP;  sp_map[32'h07] = EXE_SRAV_OP;
        sp_map[32'h08] = EXE_JR_OP;    sp_map[32'h09] = EXE_JALR_OP;
        sp_map[32'h10] = EXE_MFHI_OP;  sp_map[32'h11] = EXE_MTHI_OP;  sp_map[32'h12] = EXE_MFLO_OP;
        sp_map[32'h13] = EXE_MTLO_OP;  sp_map[32'h18] = EXE_MULT_OP;  sp_map[32'h19] = EXE_MULTU_OP;
        sp_map[32'h1A] = EXE_DIV_OP;   sp_map[32'h1B] = EXE_DIVU_OP;
        sp_map[32'h20] = EXE_ADD_OP;   sp_map[32'h21] = EXE_ADDU_OP;  sp_map[32'h22] = EXE_SUB_OP;
        sp_map[32'h23] = EXE_SUBU_OP;  sp_map[32'h24] = EXE_AND_OP;   sp_map[32'h25] = EXE_OR_OP;
        sp_map[32'h26] = EXE_XOR_OP;   sp_map[32'h27] = EXE_NOR_OP;   sp_map[32'h2A] = EXE_SLT_OP;
        sp_map[32'h2B] = EXE_SLTU_OP;
        rt_map[32'h00] = EXE_BLTZ_OP;  rt_map[32'h01] = EXE_BGEZ_OP;
        rt_map[32'h10] = EXE_BLTZAL_OP; rt_map[32'h11] = EXE_BGEZAL_OP;
        op_map[32'h02] = EXE_J_OP;     op_map[32'h03] = EXE_JAL_OP;   op_map[32'h04] = EXE_BEQ_OP;
        op_map[32'h05] = EXE_BNE_OP;   op_map[32'h06] = EXE_BLEZ_OP;  op_map[32'h07] = EXE_BGTZ_OP;
        op_map[32'h08] = EXE_ADDI_OP;  op_map[32'h09] = EXE_ADDIU_OP; op_map[32'h0A] = EXE_SLTI_OP;
        op_map[32'h0B] = EXE_SLTIU_OP; op_map[32'h0C] = EXE_ANDI_OP;  op_map[32'h0D] = EXE_ORI_OP;
        op_map[32'h0E] = EXE_XORI_OP;  op_map[32'h0F] = EXE_LUI_OP;
    endfunction

    function automatic logic [8:0] ref_dec(input logic [31:0] w);
        int op = int'(w[31:26]);
        int rt = int'(w[20:16]);
        int fn = int'(w[5:0]);
        if (op == 0)
            return sp_map.exists(fn) ? {sp_map[fn], 1'b0} : {EXE_NOP_OP, 1'b1};
        if (op == 1)
            return rt_map.exists(rt) ? {rt_map[rt], 1'b0} : {EXE_NOP_OP, 1'b1};
        return op_map.exists(op) ? {op_map[op], 1'b0} : {EXE_NOP_OP, 1'b1};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[31:26] = 6'd0;
            1: begin
                w[31:26] = 6'd1;
                if ($urandom_range(0, 1) == 1) w[19:17] = 3'b000;
            end
            2: w = 32'h0;
            3: w[31:26] = 6'($urandom_range(2, 15));
            default: ;
        endcase
        return w;
    endfunction

    typedef struct {
        logic [63:0] instr;
        logic [15:0] alu;
        logic [1:0]  ri;
    } beat_t;

    function automatic beat_t make_beat(input logic [63:0] w);
        beat_t b;
        logic [8:0] r;
        b.instr = w;
        for (int l = 0; l < 2; l++) begin
            r = ref_dec(w[l*32 +: 32]);
            b.alu[l*8 +: 8] = r[8:1];
            b.ri[l] = r[0];
        end
        return b;
    endfunction

    typedef struct {
        logic [31:0] instr;
        aluop_t      alu;
        logic        ri;
    } vec_t;

    vec_t  vecs[21];
    beat_t q2[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00221820, EXE_ADD_OP,    1'b0};
        vecs[1]  = '{32'h34220005, EXE_ORI_OP,    1'b0};
        vecs[2]  = '{32'h04210003, EXE_BGEZ_OP,   1'b0};
        vecs[3]  = '{32'hFC000000, EXE_NOP_OP,    1'b1};
        vecs[4]  = '{32'h00000000, EXE_SLL_OP,    1'b0};
        vecs[5]  = '{32'h00221822, EXE_SUB_OP,    1'b0};
        vecs[6]  = '{32'h00221824, EXE_AND_OP,    1'b0};
        vecs[7]  = '{32'h00221827, EXE_NOR_OP,    1'b0};
        vecs[8]  = '{32'h00221807, EXE_SRAV_OP,   1'b0};
        vecs[9]  = '{32'h00001812, EXE_MFLO_OP,   1'b0};
        vecs[10] = '{32'h00220018, EXE_MULT_OP,   1'b0};
        vecs[11] = '{32'h0020F809, EXE_JALR_OP,   1'b0};
        vecs[12] = '{32'h04100004, EXE_BLTZAL_OP, 1'b0};
        vecs[13] = '{32'h04110004, EXE_BGEZAL_OP, 1'b0};
        vecs[14] = '{32'h3C011234, EXE_LUI_OP,    1'b0};
        vecs[15] = '{32'h0C000010, EXE_JAL_OP,    1'b0};
        vecs[16] = '{32'h18200002, EXE_BLEZ_OP,   1'b0};
        vecs[17] = '{32'h2C22FFFF, EXE_SLTIU_OP,  1'b0};
        vecs[18] = '{32'h0000003F, EXE_NOP_OP,    1'b1};
        vecs[19] = '{32'h04030000, EXE_NOP_OP,    1'b1};
        vecs[20] = '{32'h8C220000, EXE_NOP_OP,    1'b1};
        build_maps();

        rst = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; in_instr1 = '0; out_ready1 = 1'b1;
        flush2 = 1'b0; in_valid2 = 1'b0; in_instr2 = '0; out_ready2 = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_in_ready", 64'(in_ready1), 64'd1);
        check("rst_alu", 64'(out_alu1), 64'(EXE_NOP_OP));
        check("rst_ri", 64'(out_ri1), 64'd0);
        check("rst_instr", 64'(out_instr1), 64'd0);
        check("rst_alu_2lane", 64'(out_alu2), 64'({EXE_NOP_OP, EXE_NOP_OP}));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back vectors at full throughput
        for (int i = 0; i < 21; i++) begin
            in_valid1 = 1'b1;
            in_instr1 = vecs[i].instr;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 64'(out_valid1), 64'd1);
            check($sformatf("vec%0d_alu", i), 64'(out_alu1), 64'(vecs[i].alu));
            check($sformatf("vec%0d_ri", i), 64'(out_ri1), 64'(vecs[i].ri));
            check($sformatf("vec%0d_instr", i), 64'(out_instr1), 64'(vecs[i].instr));
        end
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        check("drain_valid", 64'(out_valid1), 64'd0);

        // Backpressure: A, B accepted, C held, then all three in order
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_instr1 = 32'h00221820;
        @(posedge clk); #1;
        check("bp_a_valid", 64'(out_valid1), 64'd1);
        check("bp_a_ready", 64'(in_ready1), 64'd1);
        in_instr1 = 32'h34220005;
        @(posedge clk); #1;
        check("bp_full_ready", 64'(in_ready1), 64'd0);
        check("bp_head_a", 64'(out_alu1), 64'(EXE_ADD_OP));
        in_instr1 = 32'h04210003;
        @(posedge clk); #1;
        check("bp_hold_ready", 64'(in_ready1), 64'd0);
        check("bp_hold_head", 64'(out_instr1), 64'h00221820);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        check("bp_b_alu", 64'(out_alu1), 64'(EXE_ORI_OP));
        check("bp_b_ready", 64'(in_ready1), 64'd1);
        @(posedge clk); #1;
        check("bp_c_alu", 64'(out_alu1), 64'(EXE_BGEZ_OP));
        check("bp_c_valid", 64'(out_valid1), 64'd1);
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        check("bp_empty", 64'(out_valid1), 64'd0);

        // Flush with two buffered beats and an incoming one
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_instr1 = 32'h00221820;
        @(posedge clk); #1;
        in_instr1 = 32'h34220005;
        @(posedge clk); #1;
        check("fl_pre_full", 64'(in_ready1), 64'd0);
        flush1 = 1'b1; in_instr1 = 32'h00221826;
        @(posedge clk); #1;
        check("fl_valid", 64'(out_valid1), 64'd0);
        check("fl_ready", 64'(in_ready1), 64'd1);
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("fl_nothing%0d", k), 64'(out_valid1), 64'd0);
        end

        // Two lanes in one beat
        in_valid2 = 1'b1; in_instr2 = {32'h0022182A, 32'h00221822};
        @(posedge clk); #1;
        check("l2_valid", 64'(out_valid2), 64'd1);
        check("l2_alu", 64'(out_alu2), 64'({EXE_SLT_OP, EXE_SUB_OP}));
        check("l2_ri", 64'(out_ri2), 64'd0);
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        check("l2_single", 64'(out_valid2), 64'd0);

        // Random traffic on the 2-lane instance against a FIFO model of depth 2
        for (int c = 0; c < 400; c++) begin
            bit    push, pop;
            beat_t nb;
            flush2     = ($urandom_range(0, 29) == 0);
            in_valid2  = ($urandom_range(0, 2) != 0);
            out_ready2 = ($urandom_range(0, 3) != 0);
            in_instr2  = {rand_instr(), rand_instr()};
            push = in_valid2 && (q2.size() < 2);
            pop  = (q2.size() > 0) && out_ready2;
            nb   = make_beat(in_instr2);
            @(posedge clk); #1;
            if (flush2) q2.delete();
            else begin
                if (pop) q2.delete(0);
                if (push) q2.push_back(nb);
            end
            check("rnd_in_ready", 64'(in_ready2), 64'(q2.size() < 2));
            check("rnd_out_valid", 64'(out_valid2), 64'(q2.size() > 0));
            if (q2.size() > 0) begin
                check("rnd_instr", out_instr2, q2[0].instr);
                check("rnd_alu", 64'(out_alu2), 64'(q2[0].alu));
                check("rnd_ri", 64'(out_ri2), 64'(q2[0].ri));
            end
        end
        flush2 = 1'b1; in_valid2 = 1'b0;
        @(posedge clk); #1;
        flush2 = 1'b0; in_valid2 = 1'b1; out_ready2 = 1'b0;
        in_instr2 = {32'h00221820, 32'h00221820};
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("pre_rst_l2_alu", 64'(out_alu2), 64'({EXE_ADD_OP, EXE_ADD_OP}));

        // Async reset between edges with the 1-lane buffer full
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_instr1 = 32'h00221822;
        @(posedge clk); #1;
        in_instr1 = 32'h0022182A;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("ar_pre_full", 64'(in_ready1), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid1), 64'd0);
        check("ar_ready", 64'(in_ready1), 64'd1);
        check("ar_alu", 64'(out_alu1), 64'(EXE_NOP_OP));
        check("ar_alu_2lane", 64'(out_alu2), 64'({EXE_NOP_OP, EXE_NOP_OP}));
        check("ar_valid_2lane", 64'(out_valid2), 64'd0);
        @(negedge clk);
        rst = 1'b0; out_ready1 = 1'b1;
        @(posedge clk); #1;
        check("ar_no_partial", 64'(out_valid1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
